// File: rtl/traffic_pkg.sv
// Shared types and input indices for the traffic demand stage.
package traffic_pkg;

   typedef enum logic {DIR_NS = 1'b0, DIR_EW = 1'b1} dir_t;

   localparam int unsigned NUM_INPUTS = 4;
   localparam int unsigned DET_NS     = 0;
   localparam int unsigned DET_EW     = 1;
   localparam int unsigned PED_NS     = 2;
   localparam int unsigned PED_EW     = 3;

endpackage

// File: rtl/input_conditioner.sv
// Two-flop synchroniser followed by a debounce counter; emits the debounced
// level and a one-cycle pulse on each debounced 0->1 transition.
module input_conditioner #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_a,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Stable level only moves after DEB_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (rst_a) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         rise   <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            rise   <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/traffic_demand_unit.sv
// Demand stage for traffic_control: conditioned request latches, per-direction
// wait counters with urgency, and a registered next-direction arbiter.
module traffic_demand_unit
   import traffic_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned MAX_WAIT   = 50
) (
   input  logic clk,
   input  logic rst_a,
   input  logic det_ns_raw,
   input  logic det_ew_raw,
   input  logic ped_ns_raw,
   input  logic ped_ew_raw,
   input  logic srv_ns,
   input  logic srv_ew,
   output logic req_ns,
   output logic req_ew,
   output logic ped_req_ns,
   output logic ped_req_ew,
   output logic urgent_ns,
   output logic urgent_ew,
   output logic next_ew
);

   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

   logic [NUM_INPUTS-1:0] raw_vec;
   logic [NUM_INPUTS-1:0] rise_vec;
   logic [NUM_INPUTS-1:0] stable_unused;

   logic [WW-1:0] wait_ns;
   logic [WW-1:0] wait_ew;
   dir_t          last_srv;
   dir_t          next_dir;

   logic          req_ns_nxt;
   logic          req_ew_nxt;
   logic          ped_req_ns_nxt;
   logic          ped_req_ew_nxt;
   logic [WW-1:0] wait_ns_nxt;
   logic [WW-1:0] wait_ew_nxt;
   dir_t          last_srv_nxt;
   dir_t          next_dir_nxt;
   logic          dem_ns;
   logic          dem_ew;

   assign raw_vec = {ped_ew_raw, ped_ns_raw, det_ew_raw, det_ns_raw};
   assign next_ew = next_dir;

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cond
      input_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond (
         .clk    (clk),
         .rst_a  (rst_a),
         .raw    (raw_vec[i]),
         .stable (stable_unused[i]),
         .rise   (rise_vec[i])
      );
   end

   // Next-state: latches (set beats clear), saturating waits, arbitration
   always_comb begin
      dem_ns       = req_ns | ped_req_ns;
      dem_ew       = req_ew | ped_req_ew;
      next_dir_nxt = next_dir;
      last_srv_nxt = last_srv;

      req_ns_nxt     = rise_vec[DET_NS] | (req_ns     & ~srv_ns);
      req_ew_nxt     = rise_vec[DET_EW] | (req_ew     & ~srv_ew);
      ped_req_ns_nxt = rise_vec[PED_NS] | (ped_req_ns & ~srv_ns);
      ped_req_ew_nxt = rise_vec[PED_EW] | (ped_req_ew & ~srv_ew);

      wait_ns_nxt = wait_ns;
      if (srv_ns)                           wait_ns_nxt = '0;
      else if (dem_ns && (wait_ns != MAX_W)) wait_ns_nxt = wait_ns + WW'(1);

      wait_ew_nxt = wait_ew;
      if (srv_ew)                           wait_ew_nxt = '0;
      else if (dem_ew && (wait_ew != MAX_W)) wait_ew_nxt = wait_ew + WW'(1);

      if (dem_ns && !dem_ew) begin
         next_dir_nxt = DIR_NS;
      end else if (dem_ew && !dem_ns) begin
         next_dir_nxt = DIR_EW;
      end else if (dem_ns && dem_ew) begin
         if (urgent_ns && !urgent_ew)      next_dir_nxt = DIR_NS;
         else if (urgent_ew && !urgent_ns) next_dir_nxt = DIR_EW;
         else next_dir_nxt = (last_srv == DIR_NS) ? DIR_EW : DIR_NS;
      end

      // Simultaneous grants are a protocol violation: leave history alone
      if (srv_ns && !srv_ew)      last_srv_nxt = DIR_NS;
      else if (srv_ew && !srv_ns) last_srv_nxt = DIR_EW;
   end

   always_ff @(posedge clk) begin
      if (rst_a) begin
         req_ns     <= 1'b0;
         req_ew     <= 1'b0;
         ped_req_ns <= 1'b0;
         ped_req_ew <= 1'b0;
         wait_ns    <= '0;
         wait_ew    <= '0;
         urgent_ns  <= 1'b0;
         urgent_ew  <= 1'b0;
         last_srv   <= DIR_NS;
         next_dir   <= DIR_NS;
      end else begin
         req_ns     <= req_ns_nxt;
         req_ew     <= req_ew_nxt;
         ped_req_ns <= ped_req_ns_nxt;
         ped_req_ew <= ped_req_ew_nxt;
         wait_ns    <= wait_ns_nxt;
         wait_ew    <= wait_ew_nxt;
         urgent_ns  <= (wait_ns_nxt == MAX_W);
         urgent_ew  <= (wait_ew_nxt == MAX_W);
         last_srv   <= last_srv_nxt;
         next_dir   <= next_dir_nxt;
      end
   end

endmodule
